// File: rtl/fetch_burst_ctrl.sv
// Instruction-fetch burst controller: issues block-bounded INCR read bursts to the
// ICache and unpacks each beat into NI instruction/PC slots for the fetch FIFO.
//
// state    | meaning
// ST_ADDR  | build / hold the read address; redirects here retarget the next burst
// ST_DATA  | accept beats and write bundles (beats discarded once a redirect is pending)
// ST_DRAIN | burst was issued after a redirect arrived; swallow every beat
module fetch_burst_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                BURST_LEN = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump,
  input  logic [ADDR_W-1:0]      jump_addr,
  input  logic                   stop_fetch,
  output logic                   jump_accept,
  output logic                   arvalid,
  output logic [ADDR_W-1:0]      araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [DATA_W-1:0]      rdata,
  input  logic                   rlast,
  output logic                   rready,
  output logic                   write_fifo,
  output logic [DATA_W/32-1:0]   fetch_slot_valid,
  output logic [DATA_W/32*64-1:0] fetch_instr_pc
);

  localparam int NI    = DATA_W / 32;
  localparam int BB    = DATA_W / 8;
  localparam int BB_SH = $clog2(BB);

  typedef enum logic [1:0] {ST_ADDR, ST_DATA, ST_DRAIN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   next_addr, pend_addr, beat_addr, araddr_al, slot_pc;
  logic                pend, redir, arvalid_q, jump_accept_q, first_beat;
  logic [BB_SH-1:0]    first_off;
  logic [7:0]          blk_idx;
  logic                r_hs, keep;
  logic [NI-1:0]       slot_mask, slot_valid_q;
  logic [NI*64-1:0]    instr_pc_nx, instr_pc_q;
  logic                write_fifo_q;

  assign araddr_al = {next_addr[ADDR_W-1:BB_SH], {BB_SH{1'b0}}};
  // Beat index within the block; the burst stops at the block boundary.
  assign blk_idx   = 8'((next_addr >> BB_SH) & ADDR_W'(BURST_LEN - 1));

  assign arvalid          = arvalid_q;
  assign araddr           = arvalid_q ? araddr_al : '0;
  assign arlen            = arvalid_q ? (8'(BURST_LEN - 1) - blk_idx) : 8'd0;
  assign arsize           = 3'(BB_SH);
  assign arburst          = 2'b01;
  assign jump_accept      = jump_accept_q;
  assign write_fifo       = write_fifo_q;
  assign fetch_slot_valid = slot_valid_q;
  assign fetch_instr_pc   = instr_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ADDR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rready   = 1'b0;
    case (state)
      ST_ADDR: begin
        if (arvalid_q && arready) state_nx = (pend || jump) ? ST_DRAIN : ST_DATA;
      end
      ST_DATA: begin
        rready = pend || !stop_fetch;
        if (rvalid && rready && rlast) state_nx = ST_ADDR;
      end
      ST_DRAIN: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nx = ST_ADDR;
      end
      default: state_nx = ST_ADDR;
    endcase
  end

  assign r_hs = rvalid && rready;
  assign keep = (state == ST_DATA) && r_hs && !pend && !jump;

  always_comb begin
    slot_pc     = '0;
    slot_mask   = '0;
    instr_pc_nx = '0;
    for (int i = 0; i < NI; i++) begin
      slot_pc = beat_addr + ADDR_W'(4 * i);
      instr_pc_nx[64*i +: 64] = {32'(slot_pc), rdata[32*i +: 32]};
      slot_mask[i] = !first_beat || (32'(4 * i) >= 32'(first_off));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr     <= RESET_PC;
      pend_addr     <= '0;
      beat_addr     <= '0;
      pend          <= 1'b0;
      redir         <= 1'b0;
      arvalid_q     <= 1'b0;
      jump_accept_q <= 1'b0;
      first_beat    <= 1'b0;
      first_off     <= '0;
      write_fifo_q  <= 1'b0;
      slot_valid_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      write_fifo_q  <= keep;
      slot_valid_q  <= keep ? slot_mask : '0;
      if (keep) instr_pc_q <= instr_pc_nx;
      jump_accept_q <= 1'b0;
      case (state)
        ST_ADDR: begin
          if (!arvalid_q) begin
            if (jump) begin
              next_addr <= jump_addr;
              redir     <= 1'b1;
            end else if (!stop_fetch) begin
              arvalid_q     <= 1'b1;
              jump_accept_q <= redir;
              redir         <= 1'b0;
              first_off     <= redir ? next_addr[BB_SH-1:0] : '0;
            end
          end else begin
            // A raised request is held; late redirects are queued behind it.
            if (jump) begin
              pend      <= 1'b1;
              pend_addr <= jump_addr;
            end
            if (arready) begin
              arvalid_q  <= 1'b0;
              beat_addr  <= araddr_al;
              first_beat <= 1'b1;
            end
          end
        end
        ST_DATA, ST_DRAIN: begin
          if (jump) begin
            pend      <= 1'b1;
            pend_addr <= jump_addr;
          end
          if (r_hs) begin
            beat_addr  <= beat_addr + ADDR_W'(BB);
            first_beat <= 1'b0;
            if (rlast) begin
              if (pend || jump) begin
                next_addr <= jump ? jump_addr : pend_addr;
                redir     <= 1'b1;
                pend      <= 1'b0;
              end else begin
                next_addr <= beat_addr + ADDR_W'(BB);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_burst_ctrl.sv
// Randomized bench for fetch_burst_ctrl: two configurations (64-bit/4-beat and
// 128-bit/2-beat) each driven by an ICache responder and checked against a fetch model.
module tb_fetch_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] done = 2'b00;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] pick_jump();
    case ($urandom_range(0, 5))
      0: return 32'h0000_02C4;
      1: return 32'h0000_0400;
      2: return 32'h0000_0800;
      3: return 32'h0000_0900;
      4: return 32'hFFFF_FFE4;
      default: return $urandom & 32'h0000_FFFC;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait (done == 2'b11);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int DW  = (g == 0) ? 64 : 128;
    localparam int BL  = (g == 0) ? 4 : 2;
    localparam int NI  = DW / 32;
    localparam int BB  = DW / 8;
    localparam int BLK = BL * BB;

    logic              jump, stop_fetch, jump_accept, arvalid, arready;
    logic              rvalid, rlast, rready, write_fifo;
    logic [31:0]       jump_addr, araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [DW-1:0]     rdata;
    logic [NI-1:0]     fetch_slot_valid;
    logic [NI*64-1:0]  fetch_instr_pc;

    fetch_burst_ctrl #(
      .ADDR_W(32), .DATA_W(DW), .BURST_LEN(BL), .RESET_PC(32'h100)
    ) dut (
      .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr),
      .stop_fetch(stop_fetch), .jump_accept(jump_accept),
      .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arready(arready), .rvalid(rvalid), .rdata(rdata),
      .rlast(rlast), .rready(rready), .write_fifo(write_fifo),
      .fetch_slot_valid(fetch_slot_valid), .fetch_instr_pc(fetch_instr_pc)
    );

    initial begin : run
      logic [31:0] exp_addr, pend_addr, burst_addr, held_addr, exp_pc0, sl_addr, pc;
      logic [7:0]  held_len, exp_len;
      logic [NI-1:0] exp_mask;
      logic [DW-1:0] rd;
      logic exp_redir, pend, in_burst, first, prev_arv, prev_stop, exp_wf;
      logic sl_active, sl_valid, quiet;
      int first_off, idle, bundles, sl_left, stall_left, off_in_blk;
      int p_stop, p_jump, p_ar, p_rv;

      exp_addr = 32'h100; pend_addr = '0; burst_addr = '0; held_addr = '0; exp_pc0 = '0;
      held_len = '0; exp_len = '0; exp_mask = '0; exp_redir = 1'b0; pend = 1'b0;
      in_burst = 1'b0; first = 1'b0; prev_arv = 1'b0; prev_stop = 1'b0; exp_wf = 1'b0;
      sl_active = 1'b0; sl_valid = 1'b0; sl_addr = '0; sl_left = 0; stall_left = 0;
      first_off = 0; idle = 0; bundles = 0;
      jump = 1'b0; jump_addr = '0; stop_fetch = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; rdata = '0;

      #2;
      check_val($sformatf("c%0d_rst_arvalid", g), 64'(arvalid), 64'(0));
      check_val($sformatf("c%0d_rst_araddr", g), 64'(araddr), 64'(0));
      check_val($sformatf("c%0d_rst_arlen", g), 64'(arlen), 64'(0));
      check_val($sformatf("c%0d_rst_rready", g), 64'(rready), 64'(0));
      check_val($sformatf("c%0d_rst_wf", g), 64'(write_fifo), 64'(0));
      check_val($sformatf("c%0d_rst_ja", g), 64'(jump_accept), 64'(0));
      check_val($sformatf("c%0d_rst_slotv", g), 64'(fetch_slot_valid), 64'(0));
      check_val($sformatf("c%0d_arsize", g), 64'(arsize), 64'($clog2(BB)));
      check_val($sformatf("c%0d_arburst", g), 64'(arburst), 64'(1));
      repeat (3) @(negedge clk);

      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        #2;
        // Bundle produced by the beat accepted in the previous cycle.
        check_val($sformatf("c%0d_wf", g), 64'(write_fifo), 64'(exp_wf));
        if (exp_wf) begin
          check_val($sformatf("c%0d_slotv", g), 64'(fetch_slot_valid), 64'(exp_mask));
          for (int i = 0; i < NI; i++) begin
            if (exp_mask[i]) begin
              pc = exp_pc0 + 32'(4 * i);
              check_val($sformatf("c%0d_slot%0d", g, i),
                        fetch_instr_pc[64*i +: 64], {pc, mem_word(pc)});
            end
          end
        end

        quiet = (cyc < 40);
        p_stop = quiet ? 0 : 10;  p_jump = quiet ? 0 : 4;
        p_ar   = quiet ? 100 : 60; p_rv  = quiet ? 100 : 70;
        if (stall_left == 0 && !quiet && $urandom_range(0, 99) < 3) stall_left = 5;
        if (stall_left > 0) begin
          stop_fetch = 1'b1;
          stall_left--;
        end else begin
          stop_fetch = ($urandom_range(0, 99) < p_stop);
        end
        jump      = ($urandom_range(0, 99) < p_jump);
        jump_addr = jump ? pick_jump() : ($urandom & 32'hFFFF_FFFC);
        arready   = ($urandom_range(0, 99) < p_ar);
        if (!sl_active) sl_valid = 1'b0;
        else if (!sl_valid) sl_valid = ($urandom_range(0, 99) < p_rv);
        for (int i = 0; i < NI; i++) rd[32*i +: 32] = mem_word(sl_addr + 32'(4 * i));
        rvalid = sl_valid;
        rdata  = rd;
        rlast  = sl_active && (sl_left == 1);
        #1;

        exp_wf = 1'b0;
        if (arvalid) begin
          if (!prev_arv) begin
            off_in_blk = int'(exp_addr % 32'(BLK));
            exp_len = 8'(BL - 1 - off_in_blk / BB);
            check_val($sformatf("c%0d_araddr", g), 64'(araddr), 64'(exp_addr & ~32'(BB - 1)));
            check_val($sformatf("c%0d_arlen", g), 64'(arlen), 64'(exp_len));
            check_val($sformatf("c%0d_jaccept", g), 64'(jump_accept), 64'(exp_redir));
            check_val($sformatf("c%0d_rise_in_stall", g), 64'(prev_stop), 64'(0));
            first_off  = exp_redir ? int'(exp_addr % 32'(BB)) : 0;
            exp_redir  = 1'b0;
            held_addr  = exp_addr & ~32'(BB - 1);
            held_len   = exp_len;
          end else begin
            check_val($sformatf("c%0d_hold_addr", g), 64'(araddr), 64'(held_addr));
            check_val($sformatf("c%0d_hold_len", g), 64'(arlen), 64'(held_len));
            check_val($sformatf("c%0d_ja_extra", g), 64'(jump_accept), 64'(0));
          end
        end else begin
          check_val($sformatf("c%0d_ja_idle", g), 64'(jump_accept), 64'(0));
        end
        check_val($sformatf("c%0d_rready", g), 64'(rready),
                  64'(in_burst ? (pend || !stop_fetch) : 1'b0));

        if (jump) begin
          if (arvalid || in_burst) begin
            pend = 1'b1;
            pend_addr = jump_addr;
          end else begin
            exp_addr = jump_addr;
            exp_redir = 1'b1;
          end
        end

        if (arvalid && arready) begin
          in_burst   = 1'b1;
          burst_addr = held_addr;
          first      = 1'b1;
          sl_active  = 1'b1;
          sl_addr    = araddr;
          sl_left    = int'(arlen) + 1;
          idle = 0;
        end else if (rvalid && rready) begin
          idle = 0;
        end else begin
          idle++;
        end

        if (in_burst && rvalid && rready) begin
          if (!pend) begin
            exp_wf  = 1'b1;
            exp_pc0 = burst_addr;
            for (int i = 0; i < NI; i++) exp_mask[i] = !first || (4 * i >= first_off);
            bundles++;
          end
          first = 1'b0;
          burst_addr = burst_addr + 32'(BB);
          sl_valid = 1'b0;
          sl_addr  = sl_addr + 32'(BB);
          sl_left--;
          if (sl_left == 0) sl_active = 1'b0;
          if (rlast) begin
            in_burst = 1'b0;
            if (pend) begin
              exp_addr = pend_addr;
              exp_redir = 1'b1;
              pend = 1'b0;
            end else begin
              exp_addr = burst_addr;
            end
          end
        end
        prev_arv  = arvalid;
        prev_stop = stop_fetch;

        if (idle > 200) begin
          check_val($sformatf("c%0d_stuck", g), 64'(idle), 64'(0));
          break;
        end
      end

      check_val($sformatf("c%0d_progress", g), 64'(bundles > 20), 64'(1));
      done[g] = 1'b1;
    end
  end

endmodule
